// File: rtl/serial_comparator.sv
// Serial magnitude comparator: walks CHUNK-bit slices MSB-first,
// exiting on the first differing slice.
module serial_comparator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_b,
  output logic             A_eq_b,
  output logic             A_lt_b
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic             diff;
  logic             last;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    a_in = A;
    b_in = B;
    if (signed_mode) begin
      a_in[WIDTH-1] = ~A[WIDTH-1];
      b_in[WIDTH-1] = ~B[WIDTH-1];
    end
  end

  // Select the slice pair addressed by the chunk index.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[i*CHUNK +: CHUNK];
        sb = b_q[i*CHUNK +: CHUNK];
      end
    end
    diff = (sa != sb);
    last = (idx == '0);
  end

  // Control FSM with registered status and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      A_gt_b <= 1'b0;
      A_eq_b <= 1'b0;
      A_lt_b <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a_in;
            b_q    <= b_in;
            idx    <= LAST;
            A_gt_b <= 1'b0;
            A_eq_b <= 1'b0;
            A_lt_b <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (diff) begin
            A_gt_b <= (sa > sb);
            A_lt_b <= (sa < sb);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (last) begin
            A_eq_b <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (WIDTH=8, CHUNK=2)
// against an arithmetic reference model.
module tb_serial_comparator;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic         A_gt_b;
  logic         A_eq_b;
  logic         A_lt_b;

  int tests = 0;
  int fails = 0;

  serial_comparator #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .A_gt_b     (A_gt_b),
    .A_eq_b     (A_eq_b),
    .A_lt_b     (A_lt_b)
  );

  always #5 clk = ~clk;

  // Reference: ordinary integer compare; latency is set by the
  // position of the most significant differing bit.
  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [2:0]   fl,
    output int           k
  );
    logic gt;
    logic lt;
    if (m) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    fl = {gt, (a == b), lt};
    k = NCH;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        k = NCH - i / C;
        break;
      end
    end
  endfunction

  // Present operands with start for one edge; returns #1 after it.
  task automatic accept(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         m
  );
    start = 1'b1;
    A = a;
    B = b;
    signed_mode = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Observe a comparison from just after acceptance until done.
  task automatic wait_done(
    output int       lat,
    output logic [2:0] fl,
    output int       bcnt,
    output bit       mid_bad
  );
    lat = 0;
    fl = 3'b000;
    mid_bad = 1'b0;
    bcnt = busy ? 1 : 0;
    if ({A_gt_b, A_eq_b, A_lt_b} != 3'b000 || done) mid_bad = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        fl = {A_gt_b, A_eq_b, A_lt_b};
        break;
      end
      if ({A_gt_b, A_eq_b, A_lt_b} != 3'b000) mid_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {busy, done, A_gt_b, A_eq_b, A_lt_b});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 00000",
               {busy, done, A_gt_b, A_eq_b, A_lt_b});
    end
  endtask

  task automatic test_equal();
    int lat;
    int bc;
    logic [2:0] fl;
    bit mb;
    accept(8'hA5, 8'hA5, 1'b0);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL eq_latency: got %0d want 4", lat);
    end
    tests++;
    if (bc !== 4) begin
      fails++;
      $display("FAIL eq_busy_cycles: got %0d want 4", bc);
    end
    tests++;
    if (fl !== 3'b010) begin
      fails++;
      $display("FAIL eq_flags: got %b want 010", fl);
    end
    tests++;
    if (mb !== 1'b0) begin
      fails++;
      $display("FAIL eq_flags_clear_while_busy: got %b want 0", mb);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({done, busy, A_gt_b, A_eq_b, A_lt_b} !== 5'b00010) begin
      fails++;
      $display("FAIL eq_pulse_and_hold: got %b want 00010",
               {done, busy, A_gt_b, A_eq_b, A_lt_b});
    end
  endtask

  task automatic test_signed_mode();
    int lat;
    int bc;
    logic [2:0] fl;
    bit mb;
    accept(8'h80, 8'h7F, 1'b0);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 1 || fl !== 3'b100) begin
      fails++;
      $display("FAIL unsigned_early_exit: got lat=%0d fl=%b want lat=1 fl=100",
               lat, fl);
    end
    @(posedge clk);
    #1;
    accept(8'h80, 8'h7F, 1'b1);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 1 || fl !== 3'b001) begin
      fails++;
      $display("FAIL signed_early_exit: got lat=%0d fl=%b want lat=1 fl=001",
               lat, fl);
    end
  endtask

  task automatic test_last_slice();
    int lat;
    int bc;
    logic [2:0] fl;
    bit mb;
    @(posedge clk);
    #1;
    accept(8'h12, 8'h13, 1'b0);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 4 || fl !== 3'b001) begin
      fails++;
      $display("FAIL last_slice: got lat=%0d fl=%b want lat=4 fl=001",
               lat, fl);
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int first;
    logic [2:0] fl;
    ndone = 0;
    first = 0;
    fl = 3'b000;
    @(posedge clk);
    #1;
    accept(8'h40, 8'h40, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = i;
          fl = {A_gt_b, A_eq_b, A_lt_b};
        end
      end
      if (i == 1) begin
        start = 1'b1;
        A = 8'hFF;
        B = 8'h00;
      end
    end
    tests++;
    if (ndone !== 1 || first !== 4) begin
      fails++;
      $display("FAIL busy_start_done: got n=%0d at=%0d want n=1 at=4",
               ndone, first);
    end
    tests++;
    if (fl !== 3'b010 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_result: got fl=%b busy=%b want 010 0",
               fl, busy);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    int lat;
    int bc;
    logic [2:0] fl;
    bit mb;
    nd = 0;
    @(posedge clk);
    #1;
    accept(8'h5A, 8'h5A, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset: got %b want 00000",
               {busy, done, A_gt_b, A_eq_b, A_lt_b});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL aborted_done: got %0d pulses want 0", nd);
    end
    accept(8'h33, 8'h31, 1'b0);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 4 || fl !== 3'b100) begin
      fails++;
      $display("FAIL after_reset_cmp: got lat=%0d fl=%b want lat=4 fl=100",
               lat, fl);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    logic [2:0] fl;
    bit mb;
    @(posedge clk);
    #1;
    accept(8'hC3, 8'h03, 1'b0);
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 1 || fl !== 3'b100) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d fl=%b want lat=1 fl=100",
               lat, fl);
    end
    accept(8'h01, 8'h02, 1'b0);
    tests++;
    if ({busy, A_gt_b, A_eq_b, A_lt_b} !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_clear: got %b want 1000",
               {busy, A_gt_b, A_eq_b, A_lt_b});
    end
    wait_done(lat, fl, bc, mb);
    tests++;
    if (lat !== 4 || fl !== 3'b001) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d fl=%b want lat=4 fl=001",
               lat, fl);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mask;
    logic         m;
    logic [2:0]   efl;
    logic [2:0]   fl;
    int           ek;
    int           lat;
    int           bc;
    bit           mb;
    int           bad;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      a = W'($urandom);
      mask = W'((1 << (C * $urandom_range(0, NCH))) - 1);
      b = a ^ (W'($urandom) & mask);
      m = 1'($urandom);
      model(a, b, m, efl, ek);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      accept(a, b, m);
      wait_done(lat, fl, bc, mb);
      tests++;
      if (lat !== ek || fl !== efl || bc !== ek || mb) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_cmp a=%h b=%h s=%b: got lat=%0d fl=%b busy=%0d mid=%b want lat=%0d fl=%b",
                   a, b, m, lat, fl, bc, mb, ek, efl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_mode();
    test_last_slice();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
